sqrt_fp_ctrl: RTL and testbench

- Requester/normaliser end of the core_SQRT interface for 16-bit floats: [s|e|m] = [1|8|7], bias 127.
- Accepts a sqrt or inverse-sqrt request and screens special operands.
- Prepares the 9-bit core mantissa, issues a one-cycle do pulse, waits for the core valid, then normalises, rounds and repacks the core result.
- Sits between the FPU operand bus and the core_SQRT instance.

---
 rtl/sqrt_fp_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sqrt_fp_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sqrt_fp_ctrl.sv
// Requester/normaliser for the core_SQRT unit on 16-bit floats [s|e|m] = [1|8|7].
// Screens special operands, issues the core request and rounds/repacks the Q2.14 core result.
module sqrt_fp_ctrl #(
    parameter int unsigned LAMP_FLOAT_E_DW = 8,
    parameter int unsigned LAMP_FLOAT_F_DW = 7,
    parameter int unsigned LAMP_FLOAT_BIAS = 127
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     doSqrt_i,
    input  logic                                     doInvSqrt_i,
    input  logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0] op_i,
    output logic                                     ready_o,
    output logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0] result_o,
    output logic                                     valid_o,
    output logic                                     invalid_o,
    output logic                                     divzero_o,
    output logic                                     core_doSqrt_o,
    output logic                                     core_doInvSqrt_o,
    output logic [LAMP_FLOAT_F_DW+1:0]               core_f_o,
    input  logic [15:0]                              core_result_i,
    input  logic                                     core_valid_i
);

    localparam int unsigned EW = LAMP_FLOAT_E_DW;
    localparam int unsigned FW = LAMP_FLOAT_F_DW;
    localparam int unsigned W  = 1 + EW + FW;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StNorm, StDone} state_e;

    state_e         state_q, state_d;
    logic           is_inv_q, is_inv_d;
    logic           special_q, special_d;
    logic [EW-1:0]  half_k_q, half_k_d;
    logic [FW+1:0]  core_f_q, core_f_d;
    logic [15:0]    core_res_q, core_res_d;
    logic [W-1:0]   spec_res_q, spec_res_d;
    logic           spec_inv_q, spec_inv_d;
    logic           spec_dz_q, spec_dz_d;
    logic [W-1:0]   result_q, result_d;
    logic           invalid_q, invalid_d;
    logic           divzero_q, divzero_d;

    // Operand decode
    logic           op_sign;
    logic [EW-1:0]  op_exp;
    logic [FW-1:0]  op_man;
    logic           op_zero, op_inf, op_nan;
    logic           req, req_inv;
    logic           spec_hit, spec_inv, spec_dz;
    logic [W-1:0]   spec_res;
    logic [EW:0]    unb_exp;
    logic [FW+1:0]  issue_f;

    assign op_sign = op_i[W-1];
    assign op_exp  = op_i[W-2 -: EW];
    assign op_man  = op_i[FW-1:0];
    assign op_zero = (op_exp == '0);  // denormals flush to zero
    assign op_inf  = (&op_exp) && (op_man == '0);
    assign op_nan  = (&op_exp) && (op_man != '0);
    assign req     = doSqrt_i | doInvSqrt_i;
    assign req_inv = ~doSqrt_i & doInvSqrt_i;

    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dz  = 1'b0;
        spec_res = '0;
        if (op_nan || (op_sign && !op_zero)) begin
            spec_res = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
            spec_inv = 1'b1;
        end else if (op_zero) begin
            if (req_inv) begin
                spec_res = {1'b0, {EW{1'b1}}, {FW{1'b0}}};
                spec_dz  = 1'b1;
            end else begin
                spec_res = {op_sign, {(W-1){1'b0}}};
            end
        end else if (op_inf) begin
            spec_res = req_inv ? '0 : {1'b0, {EW{1'b1}}, {FW{1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Odd exponents shift one mantissa bit so the core operand stays in [0.25, 1).
    // Either way k/2 = floor(u/2) + 1.
    assign unb_exp = {1'b0, op_exp} - (EW+1)'(LAMP_FLOAT_BIAS);
    assign issue_f = unb_exp[0] ? {1'b1, op_man, 1'b0} : {2'b01, op_man};

    // Normalisation of the Q2.14 core result
    logic [3:0]     lead_pos;
    logic [15:0]    norm;
    logic [FW-1:0]  mant_trunc;
    logic           guard, sticky, round_up;
    logic [FW:0]    mant_sum;
    logic [EW-1:0]  exp_res;
    logic [W-1:0]   norm_res;

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < 16; i++) begin
            if (core_res_q[i]) begin
                lead_pos = 4'(i);
            end
        end
    end

    assign norm       = core_res_q << (4'd15 - lead_pos);
    assign mant_trunc = norm[14 -: FW];
    assign guard      = norm[14-FW];
    assign sticky     = |norm[13-FW:0];
    assign round_up   = guard & (sticky | mant_trunc[0]);
    assign mant_sum   = {1'b0, mant_trunc} + (FW+1)'(round_up);
    assign exp_res    = (is_inv_q ? -half_k_q : half_k_q) + EW'(lead_pos) - EW'(14)
                        + EW'(LAMP_FLOAT_BIAS) + EW'(mant_sum[FW]);
    // norm[15] is clear only when the core returned zero
    assign norm_res   = norm[15] ? {1'b0, exp_res, mant_sum[FW-1:0]} : '0;

    always_comb begin
        state_d    = state_q;
        is_inv_d   = is_inv_q;
        special_d  = special_q;
        half_k_d   = half_k_q;
        core_f_d   = core_f_q;
        core_res_d = core_res_q;
        spec_res_d = spec_res_q;
        spec_inv_d = spec_inv_q;
        spec_dz_d  = spec_dz_q;
        result_d   = result_q;
        invalid_d  = invalid_q;
        divzero_d  = divzero_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    is_inv_d = req_inv;
                    if (spec_hit) begin
                        // Specials pass through NORM so both paths share DONE timing
                        special_d  = 1'b1;
                        spec_res_d = spec_res;
                        spec_inv_d = spec_inv;
                        spec_dz_d  = spec_dz;
                        state_d    = StNorm;
                    end else begin
                        special_d = 1'b0;
                        core_f_d  = issue_f;
                        half_k_d  = unb_exp[EW:1] + EW'(1);
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (core_valid_i) begin
                    core_res_d = core_result_i;
                    state_d    = StNorm;
                end
            end
            StNorm: begin
                if (special_q) begin
                    result_d  = spec_res_q;
                    invalid_d = spec_inv_q;
                    divzero_d = spec_dz_q;
                end else begin
                    result_d  = norm_res;
                    invalid_d = 1'b0;
                    divzero_d = 1'b0;
                end
                state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            is_inv_q   <= 1'b0;
            special_q  <= 1'b0;
            half_k_q   <= '0;
            core_f_q   <= '0;
            core_res_q <= '0;
            spec_res_q <= '0;
            spec_inv_q <= 1'b0;
            spec_dz_q  <= 1'b0;
            result_q   <= '0;
            invalid_q  <= 1'b0;
            divzero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_inv_q   <= is_inv_d;
            special_q  <= special_d;
            half_k_q   <= half_k_d;
            core_f_q   <= core_f_d;
            core_res_q <= core_res_d;
            spec_res_q <= spec_res_d;
            spec_inv_q <= spec_inv_d;
            spec_dz_q  <= spec_dz_d;
            result_q   <= result_d;
            invalid_q  <= invalid_d;
            divzero_q  <= divzero_d;
        end
    end

    assign ready_o          = (state_q == StIdle);
    assign valid_o          = (state_q == StDone);
    assign core_doSqrt_o    = (state_q == StIssue) & ~is_inv_q;
    assign core_doInvSqrt_o = (state_q == StIssue) & is_inv_q;
    assign core_f_o         = core_f_q;
    assign result_o         = result_q;
    assign invalid_o        = invalid_q;
    assign divzero_o        = divzero_q;

endmodule

// File: tb/tb_sqrt_fp_ctrl.sv
// Directed bench for sqrt_fp_ctrl; the bench plays the core_SQRT side with fixed results.
module tb_sqrt_fp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        doSqrt_i, doInvSqrt_i;
    logic [15:0] op_i;
    logic        ready_o, valid_o, invalid_o, divzero_o;
    logic [15:0] result_o;
    logic        core_doSqrt_o, core_doInvSqrt_o;
    logic [8:0]  core_f_o;
    logic [15:0] core_result_i;
    logic        core_valid_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    sqrt_fp_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .doSqrt_i         (doSqrt_i),
        .doInvSqrt_i      (doInvSqrt_i),
        .op_i             (op_i),
        .ready_o          (ready_o),
        .result_o         (result_o),
        .valid_o          (valid_o),
        .invalid_o        (invalid_o),
        .divzero_o        (divzero_o),
        .core_doSqrt_o    (core_doSqrt_o),
        .core_doInvSqrt_o (core_doInvSqrt_o),
        .core_f_o         (core_f_o),
        .core_result_i    (core_result_i),
        .core_valid_i     (core_valid_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Normal operand through the core; poke raises a stray request during WAIT.
    task automatic run_core(input string tag, input logic rq_sqrt, input logic rq_inv,
                            input logic [15:0] op, input logic [8:0] exp_f,
                            input logic [15:0] core_res, input logic [15:0] exp_res,
                            input bit poke);
        logic [1:0] exp_do;
        exp_do = rq_sqrt ? 2'b10 : 2'b01;
        @(negedge clk);
        check({tag, " ready"}, {15'b0, ready_o}, 16'd1);
        doSqrt_i = rq_sqrt; doInvSqrt_i = rq_inv; op_i = op;
        @(negedge clk);
        doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; op_i = 16'h0;
        check({tag, " issue do"}, {14'b0, core_doSqrt_o, core_doInvSqrt_o}, {14'b0, exp_do});
        check({tag, " core_f"}, {7'b0, core_f_o}, {7'b0, exp_f});
        check({tag, " busy"}, {15'b0, ready_o}, 16'd0);
        if (poke) begin
            doInvSqrt_i = 1'b1; op_i = 16'h3F80;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            doInvSqrt_i = 1'b0; op_i = 16'h0;
            check({tag, " wait do"}, {14'b0, core_doSqrt_o, core_doInvSqrt_o}, 16'd0);
            check({tag, " f held"}, {7'b0, core_f_o}, {7'b0, exp_f});
            if (poke) check({tag, " wait ready"}, {15'b0, ready_o}, 16'd0);
        end
        core_valid_i = 1'b1; core_result_i = core_res;
        @(negedge clk);
        core_valid_i = 1'b0; core_result_i = 16'hDEAD;
        check({tag, " norm valid"}, {15'b0, valid_o}, 16'd0);
        @(negedge clk);
        check({tag, " valid"}, {15'b0, valid_o}, 16'd1);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " flags"}, {14'b0, invalid_o, divzero_o}, 16'd0);
        @(negedge clk);
        check({tag, " drop"}, {14'b0, valid_o, ready_o}, 16'd1);
        check({tag, " hold"}, result_o, exp_res);
    endtask

    task automatic run_spec(input string tag, input logic rq_sqrt, input logic rq_inv,
                            input logic [15:0] op, input logic [15:0] exp_res,
                            input logic exp_inv, input logic exp_dz);
        @(negedge clk);
        doSqrt_i = rq_sqrt; doInvSqrt_i = rq_inv; op_i = op;
        @(negedge clk);
        doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; op_i = 16'h0;
        check({tag, " early"}, {13'b0, valid_o, core_doSqrt_o, core_doInvSqrt_o}, 16'd0);
        @(negedge clk);
        check({tag, " valid"}, {13'b0, valid_o, core_doSqrt_o, core_doInvSqrt_o}, 16'd4);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " flags"}, {14'b0, invalid_o, divzero_o}, {14'b0, exp_inv, exp_dz});
        @(negedge clk);
        check({tag, " drop"}, {14'b0, valid_o, ready_o}, 16'd1);
    endtask

    initial begin
        rst = 1'b1;
        doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; op_i = 16'h0;
        core_result_i = 16'h0; core_valid_i = 1'b0;
        #12;
        check("rst ready/valid", {14'b0, ready_o, valid_o}, 16'd2);
        check("rst result", result_o, 16'h0);
        check("rst core", {5'b0, core_doSqrt_o, core_doInvSqrt_o, core_f_o}, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        run_core("sqrt4", 1'b1, 1'b0, 16'h4080, 9'h080, 16'h2000, 16'h4000, 1'b0);
        run_core("isqrt4", 1'b0, 1'b1, 16'h4080, 9'h080, 16'h8000, 16'h3F00, 1'b0);
        run_core("sqrt2", 1'b1, 1'b0, 16'h4000, 9'h100, 16'h2D41, 16'h3FB5, 1'b0);
        run_core("rndcarry", 1'b1, 1'b0, 16'h4080, 9'h080, 16'h3FFF, 16'h4080, 1'b0);
        run_core("both", 1'b1, 1'b1, 16'h4080, 9'h080, 16'h2000, 16'h4000, 1'b0);
        run_core("poke", 1'b1, 1'b0, 16'h4000, 9'h100, 16'h2D41, 16'h3FB5, 1'b1);

        run_spec("sqrt -1", 1'b1, 1'b0, 16'hBF80, 16'h7FC0, 1'b1, 1'b0);
        run_spec("isqrt +0", 1'b0, 1'b1, 16'h0000, 16'h7F80, 1'b0, 1'b1);
        run_spec("sqrt -0", 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0);
        run_spec("isqrt inf", 1'b0, 1'b1, 16'h7F80, 16'h0000, 1'b0, 1'b0);
        run_spec("sqrt denorm", 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
        run_spec("sqrt nan", 1'b1, 1'b0, 16'h7FC1, 16'h7FC0, 1'b1, 1'b0);

        // Leave a nonzero result and core_f, then reset asynchronously in WAIT
        @(negedge clk);
        doSqrt_i = 1'b1; op_i = 16'h4080;
        @(negedge clk);
        doSqrt_i = 1'b0; op_i = 16'h0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst ready/valid", {14'b0, ready_o, valid_o}, 16'd2);
        check("arst result", result_o, 16'h0);
        check("arst flags", {14'b0, invalid_o, divzero_o}, 16'd0);
        check("arst core", {5'b0, core_doSqrt_o, core_doInvSqrt_o, core_f_o}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        run_core("after rst", 1'b1, 1'b0, 16'h4000, 9'h100, 16'h2D41, 16'h3FB5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
